// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer: instruction kinds, store FSM
// states and default datapath widths.
package reorder_buffer_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef enum logic [1:0] {
        KIND_ALU    = 2'd0,
        KIND_LOAD   = 2'd1,
        KIND_STORE  = 2'd2,
        KIND_BRANCH = 2'd3
    } kind_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } st_state_e;

endpackage

// File: rtl/reorder_buffer_store_fsm.sv
// Store handshake for the reorder buffer: presents the head store to memory
// and reports when the memory side has accepted it.
module rob_store_fsm
    import reorder_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              abort,
    input  logic              start,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              st_done,
    output logic              st_valid,
    output logic [DATA_W-1:0] st_addr,
    output logic [DATA_W-1:0] st_data,
    output logic              retire
);

    st_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            st_addr <= '0;
            st_data <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            // Capture once on launch so the memory side sees stable values
            if (state_q == ST_IDLE && start && !abort) begin
                st_addr <= addr;
                st_data <= data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_WAIT;
            ST_WAIT: if (st_done) begin
                state_d = ST_IDLE;
                retire  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            retire  = 1'b0;
        end
    end

    assign st_valid = (state_q == ST_WAIT);

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation and retirement, out-of-order
// completion via the CDB, store handshake, mispredict flush and tail clear.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    iss_valid,
    output logic                    iss_ready,
    input  logic [1:0]              iss_kind,
    input  logic [REG_W-1:0]        iss_rd,
    output logic [TAG_W-1:0]        iss_tag,
    input  logic                    cdb_valid,
    input  logic [TAG_W-1:0]        cdb_tag,
    input  logic [DATA_W-1:0]       cdb_value,
    input  logic [DATA_W-1:0]       cdb_addr,
    input  logic                    cdb_mispred,
    input  logic [DATA_W-1:0]       cdb_target,
    output logic                    cm_valid,
    output logic [REG_W-1:0]        cm_rd,
    output logic [DATA_W-1:0]       cm_value,
    output logic [TAG_W-1:0]        cm_tag,
    output logic                    st_valid,
    output logic [DATA_W-1:0]       st_addr,
    output logic [DATA_W-1:0]       st_data,
    input  logic                    st_done,
    output logic                    flush,
    output logic [DATA_W-1:0]       flush_pc,
    input  logic                    clr,
    input  logic [TAG_W-1:0]        clr_tag,
    output logic [DEPTH-1:0]        entry_done,
    output logic [DEPTH*DATA_W-1:0] entry_value
);

    logic [TAG_W-1:0]  head, tail;
    logic [TAG_W:0]    count, count_next;
    logic [DEPTH-1:0]  busy, done, mispred, busy_next, done_next, clr_mask;
    kind_e             kind   [DEPTH];
    logic [REG_W-1:0]  rd     [DEPTH];
    logic [DATA_W-1:0] value  [DEPTH];
    logic [DATA_W-1:0] addr   [DEPTH];
    logic [DATA_W-1:0] target [DEPTH];

    logic             full, head_done, commit_fire, store_start, store_retire;
    logic             retire, alloc, cdb_hit;
    logic [TAG_W-1:0] clr_span;

    assign full        = (count == (TAG_W+1)'(DEPTH));
    assign iss_ready   = !full && !flush;
    assign iss_tag     = tail;
    assign head_done   = busy[head] && done[head];
    assign commit_fire = !flush && head_done && kind[head] != KIND_STORE;
    assign store_start = !flush && head_done && kind[head] == KIND_STORE;
    assign retire      = !flush && (commit_fire || store_retire);
    assign alloc       = iss_valid && iss_ready && !clr;
    assign cdb_hit     = cdb_valid && busy[cdb_tag];
    assign clr_span    = tail - clr_tag;
    assign entry_done  = busy & done;

    rob_store_fsm #(.DATA_W(DATA_W)) u_store (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .abort   (flush),
        .start   (store_start),
        .addr    (addr[head]),
        .data    (value[head]),
        .st_done (st_done),
        .st_valid(st_valid),
        .st_addr (st_addr),
        .st_data (st_data),
        .retire  (store_retire)
    );

    // Entries from clr_tag up to the old tail, walking the ring
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            clr_mask[i] = TAG_W'(TAG_W'(i) - clr_tag) < clr_span;
    end

    // Invalidation is applied last so a same-cycle CDB hit on a cleared tag is lost
    always_comb begin
        busy_next = busy;
        done_next = done;
        if (cdb_hit) done_next[cdb_tag] = 1'b1;
        if (retire) begin
            busy_next[head] = 1'b0;
            done_next[head] = 1'b0;
        end
        if (alloc) begin
            busy_next[tail] = 1'b1;
            done_next[tail] = 1'b0;
        end
        if (clr) begin
            busy_next = busy_next & ~clr_mask;
            done_next = done_next & ~clr_mask;
        end
        count_next = count - (TAG_W+1)'(retire) + (TAG_W+1)'(alloc);
        if (clr) count_next = count_next - {1'b0, clr_span};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            busy     <= '0;
            done     <= '0;
            mispred  <= '0;
            cm_valid <= 1'b0;
            cm_rd    <= '0;
            cm_value <= '0;
            cm_tag   <= '0;
            flush    <= 1'b0;
            flush_pc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                kind[i]   <= KIND_ALU;
                rd[i]     <= '0;
                value[i]  <= '0;
                addr[i]   <= '0;
                target[i] <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                busy     <= '0;
                done     <= '0;
                flush    <= 1'b0;
                cm_valid <= 1'b0;
            end else begin
                cm_valid <= commit_fire;
                if (commit_fire) begin
                    cm_rd    <= (kind[head] == KIND_BRANCH) ? '0 : rd[head];
                    cm_value <= value[head];
                    cm_tag   <= head;
                end
                flush <= retire && mispred[head];
                if (retire && mispred[head]) flush_pc <= target[head];
                if (cdb_hit) begin
                    value[cdb_tag]   <= cdb_value;
                    addr[cdb_tag]    <= cdb_addr;
                    mispred[cdb_tag] <= cdb_mispred;
                    target[cdb_tag]  <= cdb_target;
                end
                if (alloc) begin
                    kind[tail] <= kind_e'(iss_kind);
                    rd[tail]   <= iss_rd;
                end
                if (retire) head <= head + 1'b1;
                if (clr) tail <= clr_tag;
                else if (alloc) tail <= tail + 1'b1;
                busy  <= busy_next;
                done  <= done_next;
                count <= count_next;
            end
        end
    end

    always_comb begin
        entry_value = '0;
        for (int i = 0; i < DEPTH; i++)
            entry_value[i*DATA_W +: DATA_W] = value[i];
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill, out-of-order completion, store,
// mispredict, wrap with clr, rdy hold and reset during a store.
module tb_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int TAG_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    rdy = 1'b1;
    logic                    iss_valid = 1'b0;
    logic                    iss_ready;
    logic [1:0]              iss_kind = 2'd0;
    logic [REG_W-1:0]        iss_rd = '0;
    logic [TAG_W-1:0]        iss_tag;
    logic                    cdb_valid = 1'b0;
    logic [TAG_W-1:0]        cdb_tag = '0;
    logic [DATA_W-1:0]       cdb_value = '0;
    logic [DATA_W-1:0]       cdb_addr = '0;
    logic                    cdb_mispred = 1'b0;
    logic [DATA_W-1:0]       cdb_target = '0;
    logic                    cm_valid;
    logic [REG_W-1:0]        cm_rd;
    logic [DATA_W-1:0]       cm_value;
    logic [TAG_W-1:0]        cm_tag;
    logic                    st_valid;
    logic [DATA_W-1:0]       st_addr;
    logic [DATA_W-1:0]       st_data;
    logic                    st_done = 1'b0;
    logic                    flush;
    logic [DATA_W-1:0]       flush_pc;
    logic                    clr = 1'b0;
    logic [TAG_W-1:0]        clr_tag = '0;
    logic [DEPTH-1:0]        entry_done;
    logic [DEPTH*DATA_W-1:0] entry_value;

    int n_compared = 0;
    int n_mismatched = 0;

    reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_kind(iss_kind),
        .iss_rd(iss_rd), .iss_tag(iss_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_addr(cdb_addr), .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_value(cm_value), .cm_tag(cm_tag),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_done(st_done),
        .flush(flush), .flush_pc(flush_pc), .clr(clr), .clr_tag(clr_tag),
        .entry_done(entry_done), .entry_value(entry_value)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One allocation cycle, then the issue port goes idle again
    task automatic applyStimulus(input logic [1:0] kind, input logic [REG_W-1:0] rd);
        iss_valid = 1'b1;
        iss_kind  = kind;
        iss_rd    = rd;
        tick();
        iss_valid = 1'b0;
    endtask

    task automatic driveCdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val,
                            input logic [DATA_W-1:0] ad, input logic mp, input logic [DATA_W-1:0] tgt);
        cdb_valid   = 1'b1;
        cdb_tag     = tag;
        cdb_value   = val;
        cdb_addr    = ad;
        cdb_mispred = mp;
        cdb_target  = tgt;
        tick();
        cdb_valid   = 1'b0;
        cdb_mispred = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        doReset();
        checkOutput("rst_iss_ready", iss_ready, 1);
        checkOutput("rst_iss_tag", iss_tag, 0);
        checkOutput("rst_cm_valid", cm_valid, 0);
        checkOutput("rst_st_valid", st_valid, 0);
        checkOutput("rst_flush", flush, 0);
        checkOutput("rst_entry_done", entry_done, 0);
        checkOutput("rst_count", dut.count, 0);

        // Fill to full, then complete tag 0
        for (int i = 0; i < DEPTH; i++) applyStimulus(2'd0, REG_W'(i + 1));
        checkOutput("full_iss_ready", iss_ready, 0);
        checkOutput("full_count", dut.count, 16);
        driveCdb(4'd0, 32'h55, 32'h0, 1'b0, 32'h0);
        checkOutput("full_done0", entry_done[0], 1);
        checkOutput("full_fwd0", entry_value[0 +: DATA_W], 32'h55);
        checkOutput("full_cm_early", cm_valid, 0);
        tick();
        checkOutput("full_cm_valid", cm_valid, 1);
        checkOutput("full_cm_value", cm_value, 32'h55);
        checkOutput("full_cm_rd", cm_rd, 1);
        checkOutput("full_cm_tag", cm_tag, 0);
        checkOutput("full_iss_ready_after", iss_ready, 1);
        checkOutput("full_count_after", dut.count, 15);
        tick();
        checkOutput("full_cm_pulse", cm_valid, 0);

        // Out-of-order completion, in-order commit
        doReset();
        applyStimulus(2'd0, 5'd5);
        applyStimulus(2'd0, 5'd6);
        applyStimulus(2'd0, 5'd7);
        driveCdb(4'd2, 32'h22, 32'h0, 1'b0, 32'h0);
        checkOutput("ooo_no_commit_t2", cm_valid, 0);
        driveCdb(4'd1, 32'h11, 32'h0, 1'b0, 32'h0);
        checkOutput("ooo_no_commit_t1", cm_valid, 0);
        driveCdb(4'd0, 32'h10, 32'h0, 1'b0, 32'h0);
        checkOutput("ooo_no_commit_t0", cm_valid, 0);
        tick();
        checkOutput("ooo_c0_valid", cm_valid, 1);
        checkOutput("ooo_c0_tag", cm_tag, 0);
        checkOutput("ooo_c0_value", cm_value, 32'h10);
        checkOutput("ooo_c0_rd", cm_rd, 5);
        tick();
        checkOutput("ooo_c1_valid", cm_valid, 1);
        checkOutput("ooo_c1_tag", cm_tag, 1);
        checkOutput("ooo_c1_value", cm_value, 32'h11);
        tick();
        checkOutput("ooo_c2_valid", cm_valid, 1);
        checkOutput("ooo_c2_tag", cm_tag, 2);
        checkOutput("ooo_c2_value", cm_value, 32'h22);
        tick();
        checkOutput("ooo_end_valid", cm_valid, 0);
        checkOutput("ooo_end_count", dut.count, 0);

        // Store handshake with st_done after three cycles of st_valid
        doReset();
        applyStimulus(2'd2, 5'd3);
        driveCdb(4'd0, 32'hAB, 32'h1000, 1'b0, 32'h0);
        tick();
        for (int c = 0; c < 3; c++) begin
            checkOutput("st_valid_held", st_valid, 1);
            checkOutput("st_addr", st_addr, 32'h1000);
            checkOutput("st_data", st_data, 32'hAB);
            checkOutput("st_no_cm", cm_valid, 0);
            checkOutput("st_count_held", dut.count, 1);
            if (c == 2) st_done = 1'b1;
            tick();
        end
        st_done = 1'b0;
        checkOutput("st_valid_drop", st_valid, 0);
        checkOutput("st_retired", dut.count, 0);
        checkOutput("st_no_cm_retire", cm_valid, 0);

        // Mispredicted branch at head
        doReset();
        applyStimulus(2'd3, 5'd9);
        applyStimulus(2'd0, 5'd4);
        driveCdb(4'd0, 32'h0, 32'h0, 1'b1, 32'h200);
        checkOutput("mp_no_flush_yet", flush, 0);
        tick();
        checkOutput("mp_flush", flush, 1);
        checkOutput("mp_flush_pc", flush_pc, 32'h200);
        checkOutput("mp_cm_valid", cm_valid, 1);
        checkOutput("mp_cm_rd_zero", cm_rd, 0);
        checkOutput("mp_iss_ready", iss_ready, 0);
        tick();
        checkOutput("mp_flush_pulse", flush, 0);
        checkOutput("mp_count", dut.count, 0);
        checkOutput("mp_tail", iss_tag, 0);
        checkOutput("mp_entry_done", entry_done, 0);

        // Walk head to 14, then hold four entries 14,15,0,1
        doReset();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(2'd0, 5'd1);
            driveCdb(TAG_W'(i), 32'h1, 32'h0, 1'b0, 32'h0);
            tick();
        end
        for (int i = 0; i < 4; i++) applyStimulus(2'd0, 5'd2);
        checkOutput("wrap_tail", iss_tag, 2);
        checkOutput("wrap_count", dut.count, 4);
        clr       = 1'b1;
        clr_tag   = 4'd0;
        iss_valid = 1'b1;
        driveCdb(4'd1, 32'h77, 32'h0, 1'b0, 32'h0);
        clr       = 1'b0;
        iss_valid = 1'b0;
        checkOutput("clr_tail", iss_tag, 0);
        checkOutput("clr_count", dut.count, 2);
        checkOutput("clr_cdb_dropped", entry_done[1], 0);

        // rdy low freezes a CDB write; reasserting it lets the write land
        rdy = 1'b0;
        cdb_valid = 1'b1;
        cdb_tag   = 4'd14;
        cdb_value = 32'h99;
        tick();
        checkOutput("rdy_hold_done", entry_done[14], 0);
        checkOutput("rdy_hold_count", dut.count, 2);
        rdy = 1'b1;
        tick();
        cdb_valid = 1'b0;
        checkOutput("rdy_done", entry_done[14], 1);
        checkOutput("rdy_value", entry_value[14*DATA_W +: DATA_W], 32'h99);

        // Reset while the store FSM is waiting
        doReset();
        applyStimulus(2'd2, 5'd0);
        driveCdb(4'd0, 32'h5, 32'h40, 1'b0, 32'h0);
        tick();
        checkOutput("rstw_st_valid_pre", st_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstw_st_valid", st_valid, 0);
        checkOutput("rstw_count", dut.count, 0);
        checkOutput("rstw_cm_valid", cm_valid, 0);
        checkOutput("rstw_st_addr", st_addr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of entries (power of two, at least 4).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the value and address width.
REQ-003 The block SHALL have parameter REG_W, default 5, giving the architectural register index width.
REQ-004 The block SHALL have parameter TAG_W, default $clog2(DEPTH), giving the entry tag width.
REQ-005 The block SHALL have port clk, input, 1, the single system clock.
REQ-006 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 The block SHALL have port rdy, input, 1; when low, all state holds and outputs hold.
REQ-008 The block SHALL have these dispatch ports: iss_valid (in, 1), iss_ready (out, 1), iss_kind (in, 2: 0=ALU, 1=LOAD, 2=STORE, 3=BRANCH), iss_rd (in, REG_W), iss_tag (out, TAG_W, the tag assigned to the next allocation).
REQ-009 The block SHALL have these result ports: cdb_valid (in, 1), cdb_tag (in, TAG_W), cdb_value (in, DATA_W), cdb_addr (in, DATA_W, store address), cdb_mispred (in, 1), cdb_target (in, DATA_W).
REQ-010 The block SHALL have these commit ports: cm_valid (out, 1), cm_rd (out, REG_W), cm_value (out, DATA_W), cm_tag (out, TAG_W).
REQ-011 The block SHALL have these store ports: st_valid (out, 1), st_addr (out, DATA_W), st_data (out, DATA_W), st_done (in, 1).
REQ-012 The block SHALL have these flush ports: flush (out, 1), flush_pc (out, DATA_W), clr (in, 1), clr_tag (in, TAG_W).
REQ-013 The block SHALL have these status ports: entry_done (out, DEPTH, one bit per entry) and entry_value (out, DEPTH*DATA_W, flat bus, entry i at bits [i*DATA_W +: DATA_W]).

Function
REQ-014 The block SHALL be a circular buffer with head, tail and count registers; full SHALL be count==DEPTH and empty SHALL be count==0 (head==tail alone is never used to decide).
REQ-015 The block SHALL drive iss_ready = !full && !flush; an allocation occurs when iss_valid && iss_ready; the entry at tail is written with busy=1 and done=0; tail SHALL wrap modulo DEPTH.
REQ-016 When cdb_valid is asserted for a busy entry, the block SHALL record value, addr, mispred and target for that entry and set done=1 on the next edge; a cdb_valid for a non-busy tag SHALL be ignored.
REQ-017 When the head entry is done and its kind is ALU, LOAD or BRANCH, the block SHALL, in the same edge, pulse cm_valid for one cycle with cm_rd, cm_value and cm_tag from that entry and retire the entry; BRANCH SHALL commit with cm_rd=0.
REQ-018 When the head entry is done and its kind is STORE, the block SHALL use a 2-state FSM (IDLE, WAIT): IDLE->WAIT asserts st_valid with st_addr/st_data held stable; WAIT->IDLE on st_done, retiring the entry that same edge; cm_valid SHALL NOT pulse for stores.
REQ-019 The block SHALL retire at most one entry per cycle; minimum commit latency SHALL be 1 cycle after done is set.
REQ-020 On a simultaneous allocate and retire, the block SHALL leave count unchanged and advance both pointers; an allocate into a full buffer SHALL be impossible because iss_ready is low.
REQ-021 When a retiring entry has mispred=1, the block SHALL pulse flush for one cycle with flush_pc=target, and on the next edge set head=tail=count=0, clear all busy/done bits, and return the store FSM to IDLE.
REQ-022 On clr, the block SHALL set tail=clr_tag, invalidate every entry from clr_tag up to the old tail (wrapping), and recompute count; clr SHALL take priority over a same-cycle allocation, and a same-cycle CDB write to an invalidated tag SHALL be dropped.
REQ-023 Mispredict flush SHALL take priority over clr.
REQ-024 The block SHALL drive entry_done[i] = busy[i] && done[i], and entry_value SHALL reflect the stored value combinationally for operand forwarding.

Reset
REQ-025 On rst, the block SHALL clear head, tail and count to 0, clear all busy/done bits, and set the store FSM to IDLE.
REQ-026 On rst, the block SHALL drive cm_valid, st_valid and flush to 0 and all data outputs to 0.
REQ-027 rst SHALL override rdy, and reset mid-store SHALL abandon the store without retiring it.

Structure
REQ-028 The iss_kind encodings, the FSM state encoding and the DATA_W/REG_W defaults SHALL live in the shared constants package; DEPTH/TAG_W are per-instance.
REQ-029 The block SHALL be a single module, with one sub-module rob_store_fsm for the store handshake.

Verification
REQ-030 A bench SHALL cover fill-to-full: DEPTH=16, 16 allocations with no CDB -> iss_ready=0 and count=16; then CDB tag 0 value 0x55 -> cm_valid with cm_value=0x55 and iss_ready=1.
REQ-031 A bench SHALL cover out-of-order completion: allocate 3 ALU entries, CDB order 2,1,0 -> commits in order tags 0,1,2 on consecutive cycles.
REQ-032 A bench SHALL cover a store: a done STORE at head with addr=0x1000, data=0xAB -> st_valid held until st_done after 3 cycles; retire happens then and there is no cm_valid.
REQ-033 A bench SHALL cover mispredict: a BRANCH with mispred=1 and target=0x200 reaches head -> flush pulse, flush_pc=0x200, count=0 next cycle.
REQ-034 A bench SHALL cover wrap plus clr: head=14, tail=2 (4 entries), clr_tag=0 -> tail=0, count=2, and a CDB write to tag 1 is ignored.
REQ-035 A bench SHALL cover rdy and rst: rdy=0 during a CDB write -> no state change; rst mid-WAIT -> st_valid=0 next cycle.
